// File: rtl/oric_ram_arbiter_if.sv
// Requester and RAM-side signal bundle for the Oric system RAM arbiter.
// The arbiter connects through the slave modport; requesters and the RAM
// model sit on the master side.
interface oric_ram_arbiter_if;
    // ULA video fetch
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        vid_ack;
    logic [7:0]  vid_dout;
    // 6502 CPU
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_ack;
    logic [7:0]  cpu_dout;
    // ioctl download / tape loader
    logic        dl_wr;
    logic [15:0] dl_addr;
    logic [7:0]  dl_din;
    logic        dl_wait;
    // status
    logic        clear_busy;
    // RAM instance
    logic [15:0] ram_ad;
    logic [7:0]  ram_d;
    logic        ram_cs;
    logic        ram_we;
    logic [7:0]  ram_q;

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din,
               dl_wr, dl_addr, dl_din, ram_q,
        output vid_ack, vid_dout, cpu_ack, cpu_dout, dl_wait, clear_busy,
               ram_ad, ram_d, ram_cs, ram_we
    );

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din,
               dl_wr, dl_addr, dl_din, ram_q,
        input  vid_ack, vid_dout, cpu_ack, cpu_dout, dl_wait, clear_busy,
               ram_ad, ram_d, ram_cs, ram_we
    );
endinterface

// File: rtl/oric_ram_arbiter.sv
// Sequencer/arbiter for the 64 KiB single-port Oric system RAM.
// After reset it optionally sweeps the array with a fill value, then grants
// one access per cycle: video first, CPU and download round-robin on ties.
// Grant registers the RAM strobes; the following edge captures read data
// and pulses the requester's ack.

// Protocol checker: strobes must not hit a pending slot, video strobes
// must be at least two cycles apart.
module oric_ram_arbiter_chk (
    input logic clk_sys,
    input logic reset,
    input logic vid_req,
    input logic cpu_req,
    input logic dl_wr,
    input logic vid_pend,
    input logic cpu_pend,
    input logic dl_pend
);
    a_vid_no_overrun : assert property (@(posedge clk_sys) disable iff (reset)
        !(vid_req && vid_pend));
    a_cpu_no_overrun : assert property (@(posedge clk_sys) disable iff (reset)
        !(cpu_req && cpu_pend));
    a_dl_no_overrun  : assert property (@(posedge clk_sys) disable iff (reset)
        !(dl_wr && dl_pend));
    a_vid_spacing    : assert property (@(posedge clk_sys) disable iff (reset)
        vid_req |=> !vid_req);
endmodule

module oric_ram_arbiter #(
    parameter bit         CLEAR_ON_RESET = 1'b1,
    parameter logic [7:0] CLEAR_VALUE    = 8'hFF
) (
    input logic              clk_sys,
    input logic              reset,
    oric_ram_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [16:0] clr_cnt_q, clr_cnt_d;

    // pending request slots
    logic        vid_pend_q, vid_pend_d;
    logic [15:0] vid_addr_q, vid_addr_d;
    logic        cpu_pend_q, cpu_pend_d;
    logic        cpu_we_q, cpu_we_d;
    logic [15:0] cpu_addr_q, cpu_addr_d;
    logic [7:0]  cpu_din_q, cpu_din_d;
    logic        dl_pend_q, dl_pend_d;
    logic [15:0] dl_addr_q, dl_addr_d;
    logic [7:0]  dl_din_q, dl_din_d;

    // 1 = download wins the next cpu/dl tie
    logic        rr_dl_first_q, rr_dl_first_d;

    // access in flight on the RAM bus (granted last edge)
    logic        s1_vid_q, s1_vid_d;
    logic        s1_cpu_q, s1_cpu_d;
    logic        s1_cpu_rd_q, s1_cpu_rd_d;

    // registered outputs
    logic [15:0] ram_ad_q, ram_ad_d;
    logic [7:0]  ram_d_q, ram_d_d;
    logic        ram_cs_q, ram_cs_d;
    logic        ram_we_q, ram_we_d;
    logic        vid_ack_q, vid_ack_d;
    logic [7:0]  vid_dout_q, vid_dout_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic [7:0]  cpu_dout_q, cpu_dout_d;
    logic        dl_wait_q, dl_wait_d;
    logic        clear_busy_q, clear_busy_d;

    // Next-state: slot capture, sweep/arbitration, read-data capture.
    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        vid_pend_d    = vid_pend_q;
        vid_addr_d    = vid_addr_q;
        cpu_pend_d    = cpu_pend_q;
        cpu_we_d      = cpu_we_q;
        cpu_addr_d    = cpu_addr_q;
        cpu_din_d     = cpu_din_q;
        dl_pend_d     = dl_pend_q;
        dl_addr_d     = dl_addr_q;
        dl_din_d      = dl_din_q;
        rr_dl_first_d = rr_dl_first_q;
        s1_vid_d      = 1'b0;
        s1_cpu_d      = 1'b0;
        s1_cpu_rd_d   = 1'b0;
        ram_ad_d      = ram_ad_q;
        ram_d_d       = ram_d_q;
        ram_cs_d      = 1'b0;
        ram_we_d      = 1'b0;
        vid_ack_d     = 1'b0;
        vid_dout_d    = vid_dout_q;
        cpu_ack_d     = 1'b0;
        cpu_dout_d    = cpu_dout_q;

        // Strobes only land in an empty slot; a grant needs a full slot,
        // so capture and grant never touch the same slot in one cycle.
        if (bus.vid_req && !vid_pend_q) begin
            vid_pend_d = 1'b1;
            vid_addr_d = bus.vid_addr;
        end else begin
            vid_pend_d = vid_pend_q;
        end
        if (bus.cpu_req && !cpu_pend_q) begin
            cpu_pend_d = 1'b1;
            cpu_we_d   = bus.cpu_we;
            cpu_addr_d = bus.cpu_addr;
            cpu_din_d  = bus.cpu_din;
        end else begin
            cpu_pend_d = cpu_pend_q;
        end
        if (bus.dl_wr && !dl_pend_q) begin
            dl_pend_d = 1'b1;
            dl_addr_d = bus.dl_addr;
            dl_din_d  = bus.dl_din;
        end else begin
            dl_pend_d = dl_pend_q;
        end

        case (state_q)
            ST_CLEAR: begin
                ram_cs_d  = 1'b1;
                ram_we_d  = 1'b1;
                ram_ad_d  = clr_cnt_q[15:0];
                ram_d_d   = CLEAR_VALUE;
                clr_cnt_d = clr_cnt_q + 17'd1;
                if (clr_cnt_q == 17'h0FFFF) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
                if (vid_pend_q) begin
                    ram_cs_d   = 1'b1;
                    ram_ad_d   = vid_addr_q;
                    vid_pend_d = 1'b0;
                    s1_vid_d   = 1'b1;
                end else if (cpu_pend_q && (!dl_pend_q || !rr_dl_first_q)) begin
                    ram_cs_d      = 1'b1;
                    ram_we_d      = cpu_we_q;
                    ram_ad_d      = cpu_addr_q;
                    ram_d_d       = cpu_we_q ? cpu_din_q : ram_d_q;
                    cpu_pend_d    = 1'b0;
                    s1_cpu_d      = 1'b1;
                    s1_cpu_rd_d   = !cpu_we_q;
                    rr_dl_first_d = 1'b1;
                end else if (dl_pend_q) begin
                    ram_cs_d      = 1'b1;
                    ram_we_d      = 1'b1;
                    ram_ad_d      = dl_addr_q;
                    ram_d_d       = dl_din_q;
                    dl_pend_d     = 1'b0;
                    rr_dl_first_d = 1'b0;
                end else begin
                    ram_cs_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Data phase of last cycle's grant.
        if (s1_vid_q) begin
            vid_ack_d  = 1'b1;
            vid_dout_d = bus.ram_q;
        end else begin
            vid_ack_d = 1'b0;
        end
        if (s1_cpu_q) begin
            cpu_ack_d  = 1'b1;
            cpu_dout_d = s1_cpu_rd_q ? bus.ram_q : cpu_dout_q;
        end else begin
            cpu_ack_d = 1'b0;
        end

        // Sweep status lags the state by one edge so it drops together
        // with the first possible RUN grant.
        clear_busy_d = (state_q == ST_CLEAR);
        dl_wait_d    = (state_q == ST_CLEAR) || dl_pend_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q       <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt_q     <= 17'd0;
            vid_pend_q    <= 1'b0;
            vid_addr_q    <= 16'd0;
            cpu_pend_q    <= 1'b0;
            cpu_we_q      <= 1'b0;
            cpu_addr_q    <= 16'd0;
            cpu_din_q     <= 8'd0;
            dl_pend_q     <= 1'b0;
            dl_addr_q     <= 16'd0;
            dl_din_q      <= 8'd0;
            rr_dl_first_q <= 1'b0;
            s1_vid_q      <= 1'b0;
            s1_cpu_q      <= 1'b0;
            s1_cpu_rd_q   <= 1'b0;
            ram_ad_q      <= 16'd0;
            ram_d_q       <= 8'd0;
            ram_cs_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            vid_ack_q     <= 1'b0;
            vid_dout_q    <= 8'd0;
            cpu_ack_q     <= 1'b0;
            cpu_dout_q    <= 8'd0;
            dl_wait_q     <= CLEAR_ON_RESET;
            clear_busy_q  <= CLEAR_ON_RESET;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            vid_pend_q    <= vid_pend_d;
            vid_addr_q    <= vid_addr_d;
            cpu_pend_q    <= cpu_pend_d;
            cpu_we_q      <= cpu_we_d;
            cpu_addr_q    <= cpu_addr_d;
            cpu_din_q     <= cpu_din_d;
            dl_pend_q     <= dl_pend_d;
            dl_addr_q     <= dl_addr_d;
            dl_din_q      <= dl_din_d;
            rr_dl_first_q <= rr_dl_first_d;
            s1_vid_q      <= s1_vid_d;
            s1_cpu_q      <= s1_cpu_d;
            s1_cpu_rd_q   <= s1_cpu_rd_d;
            ram_ad_q      <= ram_ad_d;
            ram_d_q       <= ram_d_d;
            ram_cs_q      <= ram_cs_d;
            ram_we_q      <= ram_we_d;
            vid_ack_q     <= vid_ack_d;
            vid_dout_q    <= vid_dout_d;
            cpu_ack_q     <= cpu_ack_d;
            cpu_dout_q    <= cpu_dout_d;
            dl_wait_q     <= dl_wait_d;
            clear_busy_q  <= clear_busy_d;
        end
    end

    assign bus.ram_ad     = ram_ad_q;
    assign bus.ram_d      = ram_d_q;
    assign bus.ram_cs     = ram_cs_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.vid_ack    = vid_ack_q;
    assign bus.vid_dout   = vid_dout_q;
    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.cpu_dout   = cpu_dout_q;
    assign bus.dl_wait    = dl_wait_q;
    assign bus.clear_busy = clear_busy_q;

    oric_ram_arbiter_chk u_chk (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .vid_req  (bus.vid_req),
        .cpu_req  (bus.cpu_req),
        .dl_wr    (bus.dl_wr),
        .vid_pend (vid_pend_q),
        .cpu_pend (cpu_pend_q),
        .dl_pend  (dl_pend_q)
    );

endmodule

// File: tb/tb_oric_ram_arbiter.sv
// Directed bench for oric_ram_arbiter: sweep, restart on reset, CPU and
// video latency, download/CPU round-robin and three-way contention.
module tb_oric_ram_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [7:0] mem [0:65535];

    oric_ram_arbiter_if bus ();

    oric_ram_arbiter #(
        .CLEAR_ON_RESET (1'b1),
        .CLEAR_VALUE    (8'hFF)
    ) dut (
        .clk_sys (clk),
        .reset   (reset),
        .bus     (bus)
    );

    // Clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read RAM model with writes on the clock edge.
    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    end
    always @(posedge clk) begin
        if (bus.ram_cs && bus.ram_we) mem[bus.ram_ad] <= bus.ram_d;
    end
    assign bus.ram_q = mem[bus.ram_ad];

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_pulse(input logic we, input logic [15:0] a, input logic [7:0] d);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = we;
        bus.cpu_addr = a;
        bus.cpu_din  = d;
        tick();
        bus.cpu_req  = 1'b0;
    endtask

    initial begin
        int err;
        int we_cnt;
        int ack_err;
        int dl_n;
        int ncpu;
        int nack;
        int derr;
        bit cpu_out;

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.vid_req  = 1'b0; bus.vid_addr = 16'h0000;
        bus.cpu_req  = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_din = 8'h00;
        bus.dl_wr    = 1'b0; bus.dl_addr = 16'h0000; bus.dl_din = 8'h00;

        // Reset values
        repeat (3) tick();
        check_eq("rst_ram_cs", {31'd0, bus.ram_cs}, 32'd0);
        check_eq("rst_ram_we", {31'd0, bus.ram_we}, 32'd0);
        check_eq("rst_ram_ad", {16'd0, bus.ram_ad}, 32'd0);
        check_eq("rst_ram_d", {24'd0, bus.ram_d}, 32'd0);
        check_eq("rst_vid_ack", {31'd0, bus.vid_ack}, 32'd0);
        check_eq("rst_cpu_ack", {31'd0, bus.cpu_ack}, 32'd0);
        check_eq("rst_vid_dout", {24'd0, bus.vid_dout}, 32'd0);
        check_eq("rst_cpu_dout", {24'd0, bus.cpu_dout}, 32'd0);
        check_eq("rst_clear_busy", {31'd0, bus.clear_busy}, 32'd1);
        check_eq("rst_dl_wait", {31'd0, bus.dl_wait}, 32'd1);

        // Partial sweep up to 0x4000 with a CPU write left pending
        reset = 1'b0;
        err = 0;
        for (int i = 0; i <= 16384; i++) begin
            tick();
            if (bus.ram_ad !== i[15:0] || bus.ram_we !== 1'b1 || bus.ram_cs !== 1'b1) err++;
            if (i == 100) begin
                bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0400; bus.cpu_din = 8'h77;
            end else begin
                bus.cpu_req = 1'b0;
            end
        end
        check_eq("part_sweep_err", err, 32'd0);
        check_eq("part_sweep_last_ad", {16'd0, bus.ram_ad}, 32'h4000);

        // Reset mid-sweep
        reset = 1'b1;
        tick();
        tick();
        check_eq("midrst_ram_cs", {31'd0, bus.ram_cs}, 32'd0);
        check_eq("midrst_ram_ad", {16'd0, bus.ram_ad}, 32'd0);
        check_eq("midrst_clear_busy", {31'd0, bus.clear_busy}, 32'd1);
        reset = 1'b0;

        // Full sweep; a CPU read is requested during it
        err = 0; we_cnt = 0; ack_err = 0;
        for (int i = 0; i < 65536; i++) begin
            tick();
            if (i == 0) check_eq("sweep_restart_ad", {16'd0, bus.ram_ad}, 32'd0);
            if (bus.ram_cs === 1'b1 && bus.ram_we === 1'b1) we_cnt++;
            if (bus.ram_ad !== i[15:0] || bus.ram_d !== 8'hFF) err++;
            if (bus.clear_busy !== 1'b1 || bus.dl_wait !== 1'b1) err++;
            if (bus.cpu_ack !== 1'b0 || bus.vid_ack !== 1'b0) ack_err++;
            if (i == 60000) begin
                bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234;
            end else begin
                bus.cpu_req = 1'b0;
            end
        end
        check_eq("sweep_err", err, 32'd0);
        check_eq("sweep_we_cycles", we_cnt, 32'd65536);
        check_eq("sweep_no_ack", ack_err, 32'd0);
        tick();
        check_eq("end_clear_busy", {31'd0, bus.clear_busy}, 32'd0);
        check_eq("end_dl_wait", {31'd0, bus.dl_wait}, 32'd0);
        check_eq("clr_req_gnt_cs", {31'd0, bus.ram_cs}, 32'd1);
        check_eq("clr_req_gnt_we", {31'd0, bus.ram_we}, 32'd0);
        check_eq("clr_req_gnt_ad", {16'd0, bus.ram_ad}, 32'h1234);
        tick();
        check_eq("clr_req_ack", {31'd0, bus.cpu_ack}, 32'd1);
        check_eq("clr_req_dout", {24'd0, bus.cpu_dout}, 32'hFF);
        tick();
        check_eq("clr_req_ack_pulse", {31'd0, bus.cpu_ack}, 32'd0);

        // CPU write then read of 0x0400
        cpu_pulse(1'b1, 16'h0400, 8'hA5);
        check_eq("wr_ack_k", {31'd0, bus.cpu_ack}, 32'd0);
        tick();
        check_eq("wr_gnt_we", {31'd0, bus.ram_we}, 32'd1);
        check_eq("wr_gnt_ad", {16'd0, bus.ram_ad}, 32'h0400);
        check_eq("wr_gnt_d", {24'd0, bus.ram_d}, 32'hA5);
        check_eq("wr_ack_k1", {31'd0, bus.cpu_ack}, 32'd0);
        tick();
        check_eq("wr_ack_k2", {31'd0, bus.cpu_ack}, 32'd1);
        tick();
        check_eq("wr_ack_k3", {31'd0, bus.cpu_ack}, 32'd0);
        cpu_pulse(1'b0, 16'h0400, 8'h00);
        tick();
        check_eq("rd_gnt_we", {31'd0, bus.ram_we}, 32'd0);
        tick();
        check_eq("rd_ack_k2", {31'd0, bus.cpu_ack}, 32'd1);
        check_eq("rd_dout", {24'd0, bus.cpu_dout}, 32'hA5);
        tick();
        cpu_pulse(1'b1, 16'hBB80, 8'h3C);
        tick(); tick(); tick();

        // Video and CPU in the same cycle
        bus.vid_req = 1'b1; bus.vid_addr = 16'h0400;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'hBB80;
        tick();
        bus.vid_req = 1'b0; bus.cpu_req = 1'b0;
        tick();
        check_eq("vc_gnt_vid_ad", {16'd0, bus.ram_ad}, 32'h0400);
        tick();
        check_eq("vc_vid_ack", {31'd0, bus.vid_ack}, 32'd1);
        check_eq("vc_vid_dout", {24'd0, bus.vid_dout}, 32'hA5);
        check_eq("vc_cpu_ack_early", {31'd0, bus.cpu_ack}, 32'd0);
        check_eq("vc_gnt_cpu_ad", {16'd0, bus.ram_ad}, 32'hBB80);
        tick();
        check_eq("vc_cpu_ack", {31'd0, bus.cpu_ack}, 32'd1);
        check_eq("vc_cpu_dout", {24'd0, bus.cpu_dout}, 32'h3C);
        check_eq("vc_vid_ack_pulse", {31'd0, bus.vid_ack}, 32'd0);
        check_eq("vc_vid_dout_hold", {24'd0, bus.vid_dout}, 32'hA5);
        tick();

        // Download burst 0x0500..0x0507 against CPU reads every 2 cycles
        dl_n = 0; ncpu = 0; nack = 0; derr = 0; cpu_out = 1'b0;
        for (int n = 0; n < 24; n++) begin
            if (n == 2) begin
                check_eq("tie1_dl_ad", {16'd0, bus.ram_ad}, 32'h0500);
                check_eq("tie1_dl_we", {31'd0, bus.ram_we}, 32'd1);
            end
            if (n == 6) begin
                check_eq("tie2_cpu_ad", {16'd0, bus.ram_ad}, 32'h0400);
                check_eq("tie2_cpu_we", {31'd0, bus.ram_we}, 32'd0);
            end
            if (bus.cpu_ack === 1'b1) begin
                cpu_out = 1'b0;
                nack++;
                if (bus.cpu_dout !== 8'hA5) derr++;
            end
            if (bus.dl_wait === 1'b0 && dl_n < 8) begin
                bus.dl_wr = 1'b1; bus.dl_addr = 16'h0500 + 16'(dl_n); bus.dl_din = 8'hC0 + 8'(dl_n);
                dl_n++;
            end else begin
                bus.dl_wr = 1'b0;
            end
            if ((n % 2) == 0 && !cpu_out && n < 17) begin
                bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0400;
                cpu_out = 1'b1;
                ncpu++;
            end else begin
                bus.cpu_req = 1'b0;
            end
            tick();
        end
        bus.dl_wr = 1'b0; bus.cpu_req = 1'b0;
        check_eq("dl_bytes_sent", dl_n, 32'd8);
        check_eq("dl_cpu_reqs", ncpu, 32'd5);
        check_eq("dl_cpu_acks", nack, 32'd5);
        check_eq("dl_cpu_dout_err", derr, 32'd0);
        err = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem[16'h0500 + 16'(i)] !== 8'hC0 + 8'(i)) err++;
        end
        check_eq("dl_bytes_landed", err, 32'd0);
        check_eq("dl_wait_idle", {31'd0, bus.dl_wait}, 32'd0);

        // Single download so the next tie favours the CPU
        bus.dl_wr = 1'b1; bus.dl_addr = 16'h0600; bus.dl_din = 8'h5A;
        tick();
        bus.dl_wr = 1'b0;
        check_eq("dl1_wait_rise", {31'd0, bus.dl_wait}, 32'd1);
        tick();
        check_eq("dl1_wait_fall", {31'd0, bus.dl_wait}, 32'd0);
        check_eq("dl1_gnt_ad", {16'd0, bus.ram_ad}, 32'h0600);
        tick();

        // All three requesters strobe together
        bus.vid_req = 1'b1; bus.vid_addr = 16'h0503;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0600;
        bus.dl_wr   = 1'b1; bus.dl_addr = 16'h0700; bus.dl_din = 8'h99;
        tick();
        bus.vid_req = 1'b0; bus.cpu_req = 1'b0; bus.dl_wr = 1'b0;
        check_eq("all3_dl_wait_k", {31'd0, bus.dl_wait}, 32'd1);
        tick();
        check_eq("all3_k1_vid_ad", {16'd0, bus.ram_ad}, 32'h0503);
        check_eq("all3_k1_we", {31'd0, bus.ram_we}, 32'd0);
        tick();
        check_eq("all3_k2_cpu_ad", {16'd0, bus.ram_ad}, 32'h0600);
        check_eq("all3_vid_ack", {31'd0, bus.vid_ack}, 32'd1);
        check_eq("all3_vid_dout", {24'd0, bus.vid_dout}, 32'hC3);
        check_eq("all3_dl_wait_k2", {31'd0, bus.dl_wait}, 32'd1);
        tick();
        check_eq("all3_k3_dl_ad", {16'd0, bus.ram_ad}, 32'h0700);
        check_eq("all3_k3_dl_we", {31'd0, bus.ram_we}, 32'd1);
        check_eq("all3_cpu_ack", {31'd0, bus.cpu_ack}, 32'd1);
        check_eq("all3_cpu_dout", {24'd0, bus.cpu_dout}, 32'h5A);
        check_eq("all3_dl_wait_k3", {31'd0, bus.dl_wait}, 32'd0);
        tick();
        check_eq("idle_ram_cs", {31'd0, bus.ram_cs}, 32'd0);
        check_eq("idle_ram_we", {31'd0, bus.ram_we}, 32'd0);
        check_eq("idle_ram_ad_hold", {16'd0, bus.ram_ad}, 32'h0700);
        check_eq("idle_ram_d_hold", {24'd0, bus.ram_d}, 32'h99);
        check_eq("idle_vid_dout_hold", {24'd0, bus.vid_dout}, 32'hC3);
        tick();
        check_eq("all3_dl_landed", {24'd0, mem[16'h0700]}, 32'h99);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
